reg_file_burst: RTL and testbench
=================================

Name: reg_file_burst

Overview:
- Parametrised successor to the 8x16 register file: 2 combinational read ports with write-through bypass, 1 general write port, a dedicated PC write port for register PC_IDX, and a built-in burst sequencer for load-multiple/store-multiple.
- Sits between decode/writeback and the memory stage of the IITB RISC datapath.
- The burst engine walks a register mask lowest-index first, transferring one register per valid/ready handshake.

Parameters:
DATA_W, 16, register width in bits
ADDR_W, 3, register index width; NUM_REGS = 2**ADDR_W
PC_IDX, 7, index of the program-counter register (must be < NUM_REGS)

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous, active-low reset
rd_addr_a  in  ADDR_W  read port A index
rd_addr_b  in  ADDR_W  read port B index
rd_data_a  out  DATA_W  read port A data (combinational)
rd_data_b  out  DATA_W  read port B data (combinational)
wr_en  in  1  general write enable
wr_addr  in  ADDR_W  general write index
wr_data  in  DATA_W  general write data
pc_wr_en  in  1  PC write enable
pc_wr_data  in  DATA_W  PC write data
pc_out  out  DATA_W  registered contents of reg[PC_IDX]
burst_start  in  1  start burst (sampled only in IDLE)
burst_load  in  1  1 = load (write regs from burst_wr_data); 0 = store (read regs out)
burst_mask  in  NUM_REGS  bit i set = transfer reg i
burst_valid  out  1  current beat valid
burst_ready  in  1  consumer/producer accepts current beat
burst_idx  out  ADDR_W  register index of current beat
burst_rd_data  out  DATA_W  reg[burst_idx] (store mode)
burst_wr_data  in  DATA_W  data for reg[burst_idx] (load mode)
burst_busy  out  1  high in XFER
burst_done  out  1  one-cycle pulse after the last beat
wr_dropped  out  1  registered; high for 1 cycle when a wr_en was ignored

Behaviour:
- Reset (async): all registers 0, FSM IDLE, latched mask 0. burst_valid, burst_busy, burst_done and wr_dropped are 0; pc_out = 0.
- Effective write each cycle, in priority order:
  - burst load beat (burst_valid & burst_ready & load mode): write burst_wr_data to burst_idx.
  - else wr_en: write wr_data to wr_addr.
  - pc_wr_en writes PC_IDX only if no higher-priority write targets PC_IDX in the same cycle; otherwise it is silently lost.
  - A burst write and a wr_en to a different address cannot both commit: wr_en is ignored and wr_dropped is asserted on the next cycle.
  - wr_en is accepted normally in store mode and in IDLE/DONE.
- Reads: rd_data_x = effective write data if an effective write targets rd_addr_x this cycle (includes the PC port), else the stored value. burst_rd_data uses the stored value (no bypass). pc_out reflects the stored value only, with no bypass.
- FSM:
  - IDLE: on burst_start, latch mask and mode. Nonzero mask goes to XFER; zero mask goes to DONE.
  - XFER: burst_busy=1, burst_valid=1, burst_idx = lowest set bit of the latched mask. On valid&ready, clear that bit. If it was the last set bit, go to DONE.
  - DONE: burst_done=1 for exactly one cycle, then IDLE.
- burst_start outside IDLE is ignored. burst_mask and burst_load are sampled only at start.
- Throughput: 1 beat/cycle with ready held high; N set bits give burst_done on cycle N+1 after start acceptance.
- Reset mid-burst aborts immediately to IDLE. Registers already written are cleared by reset like all others.

Test Plan:
- Reset, then write R3=0x1234 via wr_en; same cycle rd_addr_a=3 -> rd_data_a=0x1234 (bypass); next cycle still 0x1234; pc_out=0.
- wr_en to R7=0x00AA and pc_wr_en=0x0055 in the same cycle -> R7=0x00AA. pc_wr_en alone with 0x0056 -> pc_out=0x0056 next cycle.
- Store burst with mask=0b10100101, ready=1: idx sequence 0,2,5,7 on consecutive cycles with matching data; burst_done 1 cycle after the idx=7 beat.
- Load burst with mask=0b00011000 and ready toggling 1,0,1: R3, then R4 written with the presented data; idx holds at 4 while ready=0; done pulses once.
- During load burst, wr_en to R1 -> R1 unchanged, wr_dropped=1 next cycle. burst_start during XFER -> ignored.
- burst_start with mask=0 -> burst_valid never high, burst_done on the next cycle. resetn low mid-burst -> busy=0, all registers 0.

Source files
------------

// File: rtl/reg_file_burst.sv
// reg_file_burst: parametrised register file with two bypassed read ports, general and PC write ports, and a load/store-multiple burst sequencer.
module reg_file_burst #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int PC_IDX = 7
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [ADDR_W-1:0]      rd_addr_a,
    input  logic [ADDR_W-1:0]      rd_addr_b,
    output logic [DATA_W-1:0]      rd_data_a,
    output logic [DATA_W-1:0]      rd_data_b,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   pc_wr_en,
    input  logic [DATA_W-1:0]      pc_wr_data,
    output logic [DATA_W-1:0]      pc_out,
    input  logic                   burst_start,
    input  logic                   burst_load,
    input  logic [2**ADDR_W-1:0]   burst_mask,
    output logic                   burst_valid,
    input  logic                   burst_ready,
    output logic [ADDR_W-1:0]      burst_idx,
    output logic [DATA_W-1:0]      burst_rd_data,
    input  logic [DATA_W-1:0]      burst_wr_data,
    output logic                   burst_busy,
    output logic                   burst_done,
    output logic                   wr_dropped
);
    localparam int NUM_REGS = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_IDX);
    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;
    state_t state, state_n;
    logic [NUM_REGS-1:0] mask_q, mask_n;
    logic load_q, load_n;
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic bl, we, pc_ok;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    assign burst_valid = state == XFER;
    assign burst_busy = state == XFER;
    assign burst_done = state == DONE;
    assign bl = burst_valid & burst_ready & load_q;
    assign we = bl | wr_en;
    assign wa = bl ? burst_idx : wr_addr;
    assign wd = bl ? burst_wr_data : wr_data;
    assign pc_ok = pc_wr_en & ~(we & (wa == PC_A));
    assign rd_data_a = (we && wa == rd_addr_a) ? wd : (pc_ok && rd_addr_a == PC_A) ? pc_wr_data : regs[rd_addr_a];
    assign rd_data_b = (we && wa == rd_addr_b) ? wd : (pc_ok && rd_addr_b == PC_A) ? pc_wr_data : regs[rd_addr_b];
    assign pc_out = regs[PC_A];
    assign burst_rd_data = regs[burst_idx];
    always_comb begin
        burst_idx = '0;
        for (int i = NUM_REGS - 1; i >= 0; i--)
            if (mask_q[i]) burst_idx = ADDR_W'(i);
    end
    always_comb begin
        state_n = state;
        mask_n = mask_q;
        load_n = load_q;
        if (state == IDLE && burst_start) begin
            mask_n = burst_mask;
            load_n = burst_load;
            state_n = |burst_mask ? XFER : DONE;
        end else if (state == XFER && burst_ready) begin
            mask_n = mask_q & ~(NUM_REGS'(1) << burst_idx);
            state_n = |mask_n ? XFER : DONE;
        end else if (state == DONE) begin
            state_n = IDLE;
        end
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            mask_q <= '0;
            load_q <= 1'b0;
            wr_dropped <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            state <= state_n;
            mask_q <= mask_n;
            load_q <= load_n;
            wr_dropped <= bl & wr_en;
            if (we) regs[wa] <= wd;
            if (pc_ok) regs[PC_A] <= pc_wr_data;
        end
    end
endmodule

// File: tb/tb_reg_file_burst.sv
// tb_reg_file_burst: directed vectors with hand-computed expectations for reg_file_burst.
module tb_reg_file_burst;
    logic clk = 0, resetn = 0;
    logic [2:0] rd_addr_a = 0, rd_addr_b = 0, wr_addr = 0, burst_idx;
    logic [15:0] rd_data_a, rd_data_b, wr_data = 0, pc_wr_data = 0, pc_out, burst_rd_data, burst_wr_data = 0;
    logic wr_en = 0, pc_wr_en = 0, burst_start = 0, burst_load = 0, burst_ready = 0;
    logic [7:0] burst_mask = 0;
    logic burst_valid, burst_busy, burst_done, wr_dropped;
    int checks = 0, failures = 0;
    always #5 clk = ~clk;
    reg_file_burst dut (
        .clk(clk), .resetn(resetn), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .pc_wr_en(pc_wr_en), .pc_wr_data(pc_wr_data), .pc_out(pc_out),
        .burst_start(burst_start), .burst_load(burst_load), .burst_mask(burst_mask),
        .burst_valid(burst_valid), .burst_ready(burst_ready), .burst_idx(burst_idx),
        .burst_rd_data(burst_rd_data), .burst_wr_data(burst_wr_data), .burst_busy(burst_busy),
        .burst_done(burst_done), .wr_dropped(wr_dropped)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic mid;
        @(negedge clk);
    endtask
    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        wr_en = 1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 0;
    endtask
    logic [2:0] sidx [4] = '{3'd0, 3'd2, 3'd5, 3'd7};
    logic [15:0] sdat [4] = '{16'h1000, 16'h2002, 16'h5005, 16'h0056};
    initial begin
        tick(); mid();
        chk("rst_busy", burst_busy, 0);
        chk("rst_valid", burst_valid, 0);
        chk("rst_done", burst_done, 0);
        chk("rst_drop", wr_dropped, 0);
        chk("rst_pc", pc_out, 0);
        resetn = 1;
        tick();
        wr_en = 1; wr_addr = 3; wr_data = 16'h1234; rd_addr_a = 3;
        mid();
        chk("bypass_a", rd_data_a, 16'h1234);
        chk("pc_zero", pc_out, 0);
        tick(); wr_en = 0; mid();
        chk("stored_a", rd_data_a, 16'h1234);
        tick();
        wr_en = 1; wr_addr = 7; wr_data = 16'h00AA; pc_wr_en = 1; pc_wr_data = 16'h0055; rd_addr_b = 7;
        mid();
        chk("wr_over_pc_byp", rd_data_b, 16'h00AA);
        tick(); wr_en = 0; pc_wr_en = 0; mid();
        chk("wr_over_pc", pc_out, 16'h00AA);
        tick(); pc_wr_en = 1; pc_wr_data = 16'h0056; mid();
        chk("pc_bypass", rd_data_b, 16'h0056);
        chk("pc_nobypass", pc_out, 16'h00AA);
        tick(); pc_wr_en = 0; mid();
        chk("pc_write", pc_out, 16'h0056);
        tick();
        wr(0, 16'h1000); wr(2, 16'h2002); wr(5, 16'h5005);
        burst_start = 1; burst_load = 0; burst_mask = 8'hA5; burst_ready = 1;
        tick(); burst_start = 0;
        for (int k = 0; k < 4; k++) begin
            mid();
            chk("st_valid", burst_valid, 1);
            chk("st_idx", burst_idx, sidx[k]);
            chk("st_data", burst_rd_data, sdat[k]);
            chk("st_nodone", burst_done, 0);
            tick();
        end
        mid();
        chk("st_done", burst_done, 1);
        chk("st_valid_off", burst_valid, 0);
        tick(); mid();
        chk("st_done_1cyc", burst_done, 0);
        tick();
        burst_start = 1; burst_load = 1; burst_mask = 8'h18;
        tick(); burst_start = 0;
        burst_ready = 1; burst_wr_data = 16'hAB03;
        wr_en = 1; wr_addr = 1; wr_data = 16'hFFFF; rd_addr_a = 3; rd_addr_b = 1;
        mid();
        chk("ld_idx3", burst_idx, 3);
        chk("ld_byp3", rd_data_a, 16'hAB03);
        chk("ld_r1_nobyp", rd_data_b, 0);
        tick(); wr_en = 0; burst_ready = 0; burst_wr_data = 16'hBEEF; rd_addr_a = 4;
        mid();
        chk("ld_dropped", wr_dropped, 1);
        chk("ld_idx_hold", burst_idx, 4);
        chk("ld_valid_hold", burst_valid, 1);
        chk("ld_r4_nowrite", rd_data_a, 0);
        tick(); burst_ready = 1; burst_wr_data = 16'hAB04; burst_start = 1; burst_mask = 8'hFF;
        mid();
        chk("ld_idx4", burst_idx, 4);
        chk("ld_drop_clr", wr_dropped, 0);
        tick(); burst_start = 0; burst_ready = 0; rd_addr_a = 3; rd_addr_b = 4;
        mid();
        chk("ld_done", burst_done, 1);
        chk("ld_r3", rd_data_a, 16'hAB03);
        chk("ld_r4", rd_data_b, 16'hAB04);
        tick(); rd_addr_a = 1; mid();
        chk("ld_done_1cyc", burst_done, 0);
        chk("ld_r1_kept", rd_data_a, 0);
        tick(); mid();
        chk("start_ignored", burst_busy, 0);
        burst_start = 1; burst_mask = 8'h00; burst_load = 0; burst_ready = 1;
        tick(); burst_start = 0; mid();
        chk("zm_valid", burst_valid, 0);
        chk("zm_done", burst_done, 1);
        tick(); mid();
        chk("zm_done_1cyc", burst_done, 0);
        chk("zm_valid2", burst_valid, 0);
        tick();
        burst_start = 1; burst_mask = 8'hFF; burst_ready = 0;
        tick(); burst_start = 0; mid();
        chk("mid_busy", burst_busy, 1);
        resetn = 0; rd_addr_a = 3; rd_addr_b = 7;
        #1;
        chk("ab_busy", burst_busy, 0);
        chk("ab_valid", burst_valid, 0);
        chk("ab_r3", rd_data_a, 0);
        chk("ab_r7", rd_data_b, 0);
        chk("ab_pc", pc_out, 0);
        tick(); resetn = 1; tick(); mid();
        chk("ab_idle", burst_busy, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
